// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - op codes, FSM states and helpers shared by the multi-cycle ALU
package alu_mc_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_OR2   = 4'd3;
    localparam logic [3:0] OP_ANDN  = 4'd4;
    localparam logic [3:0] OP_ORN   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MULT  = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_MFHI  = 4'd12;
    localparam logic [3:0] OP_MFLO  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Ops 8..11 go through the iterative mul/div unit
    function automatic logic is_long_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_mc_mdu_iter.sv
// rtl/alu_mc_mdu_iter.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             fin_o,
    output logic             dz_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q, neg_p_q, neg_r_q, dz_q;

    logic             sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, shifted, sub_diff;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH-1:0] q_n, r_n;

    // op_i[0]=0 selects the signed variant; work on magnitudes, fix signs at the end
    assign sgn   = ~op_i[0];
    assign a_mag = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;

    always_comb begin
        acc_d    = acc_q;
        x_d      = x_q;
        add_sum  = {1'b0, acc_q} + (x_q[0] ? {1'b0, m_q} : '0);
        shifted  = {acc_q, x_q[WIDTH-1]};
        sub_diff = shifted - {1'b0, m_q};
        if (is_div_q) begin
            if (!sub_diff[WIDTH]) begin
                acc_d = sub_diff[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = add_sum[WIDTH:1];
            x_d   = {add_sum[0], x_q[WIDTH-1:1]};
        end
    end

    assign prod   = {acc_q, x_q};
    assign prod_n = neg_p_q ? -prod : prod;
    assign q_n    = neg_p_q ? -x_q : x_q;
    assign r_n    = neg_r_q ? -acc_q : acc_q;

    // Divide-by-zero leaves the dividend magnitude in acc, so hi comes out as srca
    assign hi_o  = is_div_q ? r_n : prod_n[2*WIDTH-1:WIDTH];
    assign lo_o  = is_div_q ? (dz_q ? '1 : q_n) : prod_n[WIDTH-1:0];
    assign fin_o = step_i && (cnt_q == CNT_W'(WIDTH - 1));
    assign dz_o  = dz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            x_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else if (load_i) begin
            acc_q    <= '0;
            x_q      <= a_mag;
            m_q      <= b_mag;
            cnt_q    <= '0;
            is_div_q <= op_i[1];
            neg_p_q  <= sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r_q  <= sgn & op_i[1] & a_i[WIDTH-1];
            dz_q     <= op_i[1] & (b_i == '0);
        end else if (step_i) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - EX-stage ALU: single-cycle logic/arith ops plus iterative mul/div with HI/LO
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_zero
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             zero_q, zero_d, done_q, done_d, dz_q, dz_d;
    logic             accept;
    logic [WIDTH-1:0] short_res, mdu_hi, mdu_lo;
    logic             mdu_fin, mdu_dz;

    assign ready  = (state_q == ST_IDLE);
    assign accept = start && ready;

    mdu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (reset_n),
        .load_i (accept && is_long_op(op)),
        .step_i (state_q == ST_RUN),
        .op_i   (op[1:0]),
        .a_i    (srca),
        .b_i    (srcb),
        .hi_o   (mdu_hi),
        .lo_o   (mdu_lo),
        .fin_o  (mdu_fin),
        .dz_o   (mdu_dz)
    );

    always_comb begin
        short_res = '0;
        case (op)
            OP_AND:         short_res = srca & srcb;
            OP_OR, OP_OR2:  short_res = srca | srcb;
            OP_ADD:         short_res = srca + srcb;
            OP_ANDN:        short_res = srca & ~srcb;
            OP_ORN:         short_res = srca | ~srcb;
            OP_SUB:         short_res = srca - srcb;
            OP_SLT:         short_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            OP_MFHI:        short_res = hi_q;
            OP_MFLO:        short_res = lo_q;
            default:        short_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_long_op(op)) begin
                        state_d = ST_RUN;
                    end else begin
                        result_d = short_res;
                        done_d   = 1'b1;
                        dz_d     = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (mdu_fin) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d  = ST_IDLE;
                hi_d     = mdu_hi;
                lo_d     = mdu_lo;
                result_d = mdu_lo;
                done_d   = 1'b1;
                dz_d     = mdu_dz;
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
